seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It accepts a display frame (8 hex nibbles, active digit count, dot position) through a valid/ready handshake and holds it in a pending register. The frame is applied atomically at a frame boundary, so the display never tears. It then cycles the digit anodes with a dead-time gap against ghosting, driving hex-decoded segments and the decimal point for the selected digit.

---
 rtl/seg7_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
// Frames are staged in a pending register and swapped in only at a frame boundary.
module seg7_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_data,
  input  logic [3:0]  upd_count,
  input  logic [2:0]  upd_dot,
  input  logic        upd_dot_en,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [2:0]  digit_idx,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Segment pattern {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] clamp_count(input logic [3:0] c);
    logic [3:0] r;
    if (c > 4'd8) begin
      r = 4'd8;
    end else begin
      r = c;
    end
    return r;
  endfunction

  state_t         state_r, state_s;
  logic           pend_r, pend_s;
  logic [31:0]    pend_data_r;
  logic [3:0]     pend_count_r;
  logic [2:0]     pend_dot_r;
  logic           pend_dot_en_r;
  logic [31:0]    act_data_r, act_data_s;
  logic [3:0]     act_count_r, act_count_s;
  logic [2:0]     act_dot_r, act_dot_s;
  logic           act_dot_en_r, act_dot_en_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [2:0]     idx_r, idx_s;

  logic           accept_s;
  logic           boundary_s;
  logic           apply_s;
  logic           lit_s;
  logic [3:0]     nibble_s;
  logic [7:0]     an_s;
  logic [6:0]     seg_s;
  logic           dp_s;
  logic           tick_s;

  // Next-state: handshake, atomic apply at frame boundary, slot counters.
  always_comb begin
    accept_s     = upd_valid && upd_ready;
    boundary_s   = (state_r == SCAN) && (cnt_r == CNT_LAST) && (idx_r == 3'd7);
    apply_s      = pend_r && ((state_r == IDLE) || boundary_s);
    state_s      = state_r;
    cnt_s        = cnt_r;
    idx_s        = idx_r;
    act_data_s   = act_data_r;
    act_count_s  = act_count_r;
    act_dot_s    = act_dot_r;
    act_dot_en_s = act_dot_en_r;

    if (apply_s) begin
      act_data_s   = pend_data_r;
      act_count_s  = pend_count_r;
      act_dot_s    = pend_dot_r;
      act_dot_en_s = pend_dot_en_r;
      cnt_s        = '0;
      idx_s        = 3'd0;
      state_s      = (pend_count_r == 4'd0) ? IDLE : SCAN;
    end else if (state_r == SCAN) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s = '0;
        idx_s = idx_r + 3'd1;
      end else begin
        cnt_s = cnt_r + CW'(1);
        idx_s = idx_r;
      end
    end else begin
      cnt_s = '0;
      idx_s = 3'd0;
    end

    // accept and apply are mutually exclusive: accept needs pend_r low, apply needs it high
    if (accept_s) begin
      pend_s = 1'b1;
    end else if (apply_s) begin
      pend_s = 1'b0;
    end else begin
      pend_s = pend_r;
    end
  end

  // Output decode from next-state values so the flopped outputs carry no extra lag.
  always_comb begin
    lit_s    = (state_s == SCAN) && (cnt_s >= CNT_BLANK) && ({1'b0, idx_s} < act_count_s);
    nibble_s = act_data_s[{idx_s, 2'b00} +: 4];
    if (state_s == SCAN) begin
      an_s   = lit_s ? ~(8'h01 << idx_s) : 8'hFF;
      seg_s  = hex_to_seg(nibble_s);
      dp_s   = !(lit_s && act_dot_en_s && (idx_s == act_dot_s));
      tick_s = (cnt_s == CNT_LAST) && (idx_s == 3'd7);
    end else begin
      an_s   = 8'hFF;
      seg_s  = 7'h7F;
      dp_s   = 1'b1;
      tick_s = 1'b0;
    end
  end

  // Control state, counters and active frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pend_r       <= 1'b0;
      cnt_r        <= '0;
      idx_r        <= 3'd0;
      act_data_r   <= 32'h0000_0000;
      act_count_r  <= 4'd0;
      act_dot_r    <= 3'd0;
      act_dot_en_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_r       <= pend_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      act_data_r   <= act_data_s;
      act_count_r  <= act_count_s;
      act_dot_r    <= act_dot_s;
      act_dot_en_r <= act_dot_en_s;
    end
  end

  // Pending frame capture on an accepted update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_r   <= 32'h0000_0000;
      pend_count_r  <= 4'd0;
      pend_dot_r    <= 3'd0;
      pend_dot_en_r <= 1'b0;
    end else if (accept_s) begin
      pend_data_r   <= upd_data;
      pend_count_r  <= clamp_count(upd_count);
      pend_dot_r    <= upd_dot;
      pend_dot_en_r <= upd_dot_en;
    end else begin
      pend_data_r   <= pend_data_r;
      pend_count_r  <= pend_count_r;
      pend_dot_r    <= pend_dot_r;
      pend_dot_en_r <= pend_dot_en_r;
    end
  end

  // Registered display and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 8'hFF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      digit_idx  <= 3'd0;
      frame_tick <= 1'b0;
      upd_ready  <= 1'b1;
    end else begin
      an_n       <= an_s;
      seg_n      <= seg_s;
      dp_n       <= dp_s;
      digit_idx  <= idx_s;
      frame_tick <= tick_s;
      upd_ready  <= !pend_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle model pushes expected outputs per edge,
// which are popped and compared just after the edge.
module tb_seg7_scan_ctrl;
  localparam int DIV   = 20;
  localparam int BLANK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_data;
  logic [3:0]  upd_count;
  logic [2:0]  upd_dot;
  logic        upd_dot_en;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_data(upd_data),
    .upd_count(upd_count), .upd_dot(upd_dot), .upd_dot_en(upd_dot_en),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  int errors = 0;
  int checks = 0;
  logic [20:0] expq[$];

  // model state
  bit          m_scan, m_pend;
  logic [31:0] m_pdata, m_adata;
  int          m_pcnt, m_acnt, m_pdot, m_adot;
  bit          m_pen, m_aen;
  int          m_cnt, m_idx;

  int          cyc = 0;
  int          dut_acc = 0;
  int          tick_count = 0;
  int          last_tick = -1;
  logic [7:0]  lit_mask = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[v];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit         acc, bnd, lit;
    logic [7:0] an;
    logic [3:0] nib;
    logic [6:0] seg;
    logic       dp, tk;
    if (!rst_n) begin
      m_scan = 0; m_pend = 0; m_cnt = 0; m_idx = 0;
      m_acnt = 0; m_adata = '0; m_adot = 0; m_aen = 0;
    end else begin
      acc = upd_valid && !m_pend;
      bnd = m_scan && (m_cnt == DIV - 1) && (m_idx == 7);
      if (m_pend && (!m_scan || bnd)) begin
        m_adata = m_pdata; m_acnt = m_pcnt; m_adot = m_pdot; m_aen = m_pen;
        m_pend = 0; m_cnt = 0; m_idx = 0;
        m_scan = (m_acnt != 0);
      end else if (m_scan) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DIV) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 8;
        end
      end
      if (acc) begin
        m_pend = 1; m_pdata = upd_data; m_pdot = int'(upd_dot); m_pen = upd_dot_en;
        m_pcnt = (upd_count > 4'd8) ? 8 : int'(upd_count);
      end
    end
    if (m_scan) begin
      lit = (m_cnt >= BLANK) && (m_idx < m_acnt);
      an  = 8'hFF;
      if (lit) an[m_idx] = 1'b0;
      nib = m_adata[m_idx*4 +: 4];
      seg = seg_ref(nib);
      dp  = !(lit && m_aen && (m_idx == m_adot));
      tk  = (m_idx == 7) && (m_cnt == DIV - 1);
    end else begin
      an = 8'hFF; seg = 7'h7F; dp = 1'b1; tk = 1'b0;
    end
    expq.push_back({an, seg, dp, 3'(m_idx), tk, !m_pend});
  endtask

  task automatic tick();
    logic [20:0] exp;
    if (rst_n && upd_valid && upd_ready) dut_acc++;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    exp = expq.pop_front();
    check("outs{an,seg,dp,idx,tick,ready}", {an_n, seg_n, dp_n, digit_idx, frame_tick, upd_ready}, exp);
    lit_mask = lit_mask | ~an_n;
    if (!m_scan) last_tick = -1;
    if (frame_tick) begin
      if (last_tick >= 0) check("tick_period", cyc - last_tick, 8 * DIV);
      last_tick = cyc;
      tick_count++;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] c, input logic [2:0] dot, input logic en);
    upd_valid = 1'b1; upd_data = d; upd_count = c; upd_dot = dot; upd_dot_en = en;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    int seen;
    int t0;
    rst_n = 1'b1; upd_valid = 1'b0; upd_data = '0; upd_count = '0; upd_dot = '0; upd_dot_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_an", an_n, 8'hFF);
    check("rst_seg", seg_n, 7'h7F);
    check("rst_ready", upd_ready, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // basic scan
    send(32'h0000_1234, 4'd4, 3'd2, 1'b1);
    repeat (330) tick();

    // mid-frame update during slot 2, then backpressure with a second value
    for (int i = 0; i < 200 && !(m_scan && m_idx == 2); i++) tick();
    send(32'hFFFF_FFFF, 4'd8, 3'd0, 1'b0);
    upd_valid = 1'b1; upd_data = 32'hA5C3_0E9B; upd_count = 4'd8; upd_dot = 3'd5; upd_dot_en = 1'b1;
    seen = dut_acc;
    for (int i = 0; i < 400 && dut_acc == seen; i++) tick();
    check("bp_accept", dut_acc - seen, 1);
    repeat (10) tick();
    upd_valid = 1'b0;
    check("bp_single", dut_acc - seen, 1);
    repeat (330) tick();

    // blanking
    send(32'h1111_1111, 4'd0, 3'd0, 1'b0);
    repeat (200) tick();
    t0 = tick_count;
    repeat (200) tick();
    check("blank_ticks", tick_count - t0, 0);
    check("blank_an", an_n, 8'hFF);

    // clamp
    send(32'h7654_3210, 4'd12, 3'd7, 1'b1);
    lit_mask = 8'h00;
    repeat (170) tick();
    check("clamp_lit", lit_mask, 8'hFF);

    // reset mid-scan with a pending update outstanding
    for (int i = 0; i < 200 && !(m_scan && m_idx == 3); i++) tick();
    send(32'h0000_0ABC, 4'd3, 3'd1, 1'b1);
    repeat (6) tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_an", an_n, 8'hFF);
    check("midrst_seg", seg_n, 7'h7F);
    check("midrst_dp", dp_n, 1'b1);
    check("midrst_tick", frame_tick, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("post_rst_ready", upd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
